// File: rtl/core_alu_sched.sv
// rtl/core_alu_sched.sv - round-robin two-requester scheduler for the shared registered ALU; optional CORE_ALU_SCHED_STATS_EN accept counters
module core_alu_sched #(
  parameter int TAG_W = 4,
  parameter int OP_W  = 6
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [OP_W-1:0]  REQ0_OP,
  input  logic [31:0]      REQ0_RS1,
  input  logic [31:0]      REQ0_RS2,
  input  logic [31:0]      REQ0_IMM,
  input  logic [TAG_W-1:0] REQ0_TAG,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [OP_W-1:0]  REQ1_OP,
  input  logic [31:0]      REQ1_RS1,
  input  logic [31:0]      REQ1_RS2,
  input  logic [31:0]      REQ1_IMM,
  input  logic [TAG_W-1:0] REQ1_TAG,
`ifdef CORE_ALU_SCHED_STATS_EN
  input  logic             STAT_CLR,
  output logic [15:0]      STAT0_CNT,
  output logic [15:0]      STAT1_CNT,
`endif
  output logic [32:0]      ALU_SEL,
  output logic [31:0]      ALU_RS1,
  output logic [31:0]      ALU_RS2,
  output logic [31:0]      ALU_IMM,
  input  logic [31:0]      ALU_RESULT,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic             RSP_SRC,
  output logic [TAG_W-1:0] RSP_TAG,
  output logic [31:0]      RSP_DATA,
  output logic             RSP_ERR
);

  localparam int NUM_OPS = 33;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic            last_q;
  logic            grant_any;
  logic            grant_src;
  logic [OP_W-1:0] grant_op;
  logic            grant_illegal;
  logic [32:0]     grant_onehot;

  // Round-robin pick: a lone requester wins outright, a tie goes to the one not granted last
  always_comb begin
    grant_any = 1'b0;
    grant_src = 1'b0;
    if (state_q == IDLE) begin
      grant_any = REQ0_VALID | REQ1_VALID;
      if (REQ0_VALID && REQ1_VALID) grant_src = ~last_q;
      else                          grant_src = REQ1_VALID;
    end
  end

  assign REQ0_READY = grant_any & ~grant_src;
  assign REQ1_READY = grant_any &  grant_src;

  // Winner's op code decoded to the ALU one-hot strobe; out-of-range codes strobe nothing
  always_comb begin
    grant_op      = grant_src ? REQ1_OP : REQ0_OP;
    grant_illegal = (32'(grant_op) >= 32'(NUM_OPS));
    grant_onehot  = '0;
    if (!grant_illegal) grant_onehot = 33'd1 << grant_op;
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Issue one cycle, wait one cycle for the ALU's registered result, then hold the response
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = RESP;
      RESP:    if (RSP_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand/strobe launch on accept, strobe drop after issue, result capture and response handshake
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      last_q    <= 1'b1;
      ALU_SEL   <= '0;
      ALU_RS1   <= '0;
      ALU_RS2   <= '0;
      ALU_IMM   <= '0;
      RSP_VALID <= 1'b0;
      RSP_SRC   <= 1'b0;
      RSP_TAG   <= '0;
      RSP_DATA  <= '0;
      RSP_ERR   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            ALU_SEL <= grant_onehot;
            ALU_RS1 <= grant_src ? REQ1_RS1 : REQ0_RS1;
            ALU_RS2 <= grant_src ? REQ1_RS2 : REQ0_RS2;
            ALU_IMM <= grant_src ? REQ1_IMM : REQ0_IMM;
            RSP_SRC <= grant_src;
            RSP_TAG <= grant_src ? REQ1_TAG : REQ0_TAG;
            RSP_ERR <= grant_illegal;
            last_q  <= grant_src;
          end
        end
        ISSUE: ALU_SEL <= '0;
        WAIT: begin
          RSP_DATA  <= ALU_RESULT;
          RSP_VALID <= 1'b1;
        end
        RESP: if (RSP_READY) RSP_VALID <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef CORE_ALU_SCHED_STATS_EN
  logic [15:0] stat0_q, stat1_q;

  // Saturating per-requester accept counters; a clear beats a same-cycle accept
  always_ff @(posedge CLK) begin
    if (!RST_N || STAT_CLR) begin
      stat0_q <= '0;
      stat1_q <= '0;
    end else if (grant_any) begin
      if (!grant_src && stat0_q != 16'hFFFF) stat0_q <= stat0_q + 16'd1;
      if ( grant_src && stat1_q != 16'hFFFF) stat1_q <= stat1_q + 16'd1;
    end
  end

  assign STAT0_CNT = stat0_q;
  assign STAT1_CNT = stat1_q;
`endif

endmodule

// File: tb/tb_core_alu_sched.sv
// tb/tb_core_alu_sched.sv - self-checking bench for core_alu_sched with a behavioural ALU and scheduler model
module tb_core_alu_sched;

  logic        CLK;
  logic        RST_N;
  logic        REQ0_VALID, REQ0_READY;
  logic [5:0]  REQ0_OP;
  logic [31:0] REQ0_RS1, REQ0_RS2, REQ0_IMM;
  logic [3:0]  REQ0_TAG;
  logic        REQ1_VALID, REQ1_READY;
  logic [5:0]  REQ1_OP;
  logic [31:0] REQ1_RS1, REQ1_RS2, REQ1_IMM;
  logic [3:0]  REQ1_TAG;
  logic [32:0] ALU_SEL;
  logic [31:0] ALU_RS1, ALU_RS2, ALU_IMM;
  logic [31:0] ALU_RESULT = '0;
  logic        RSP_VALID, RSP_READY, RSP_SRC, RSP_ERR;
  logic [3:0]  RSP_TAG;
  logic [31:0] RSP_DATA;
`ifdef CORE_ALU_SCHED_STATS_EN
  logic        STAT_CLR = 1'b0;
  logic [15:0] STAT0_CNT, STAT1_CNT;
`endif

  int checks = 0;
  int passed = 0;

  core_alu_sched #(.TAG_W(4), .OP_W(6)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_OP(REQ0_OP),
    .REQ0_RS1(REQ0_RS1), .REQ0_RS2(REQ0_RS2), .REQ0_IMM(REQ0_IMM), .REQ0_TAG(REQ0_TAG),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_OP(REQ1_OP),
    .REQ1_RS1(REQ1_RS1), .REQ1_RS2(REQ1_RS2), .REQ1_IMM(REQ1_IMM), .REQ1_TAG(REQ1_TAG),
`ifdef CORE_ALU_SCHED_STATS_EN
    .STAT_CLR(STAT_CLR), .STAT0_CNT(STAT0_CNT), .STAT1_CNT(STAT1_CNT),
`endif
    .ALU_SEL(ALU_SEL), .ALU_RS1(ALU_RS1), .ALU_RS2(ALU_RS2), .ALU_IMM(ALU_IMM),
    .ALU_RESULT(ALU_RESULT),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_SRC(RSP_SRC),
    .RSP_TAG(RSP_TAG), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RV32I operation by op code: I-type uses IMM, R-type and branches use RS2, loads/stores give the address
  function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] imm);
    logic [31:0] r;
    case (op)
      0:  r = a + imm;
      1:  r = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
      2:  r = (a < imm) ? 32'd1 : 32'd0;
      3:  r = a ^ imm;
      4:  r = a | imm;
      5:  r = a & imm;
      6:  r = a << imm[4:0];
      7:  r = a >> imm[4:0];
      8:  r = $unsigned($signed(a) >>> imm[4:0]);
      9:  r = a + b;
      10: r = a - b;
      11: r = a << b[4:0];
      12: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      13: r = (a < b) ? 32'd1 : 32'd0;
      14: r = a ^ b;
      15: r = a >> b[4:0];
      16: r = $unsigned($signed(a) >>> b[4:0]);
      17: r = a | b;
      18: r = a & b;
      19: r = (a == b) ? 32'd1 : 32'd0;
      20: r = (a != b) ? 32'd1 : 32'd0;
      21: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      22: r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      23: r = (a < b) ? 32'd1 : 32'd0;
      24: r = (a >= b) ? 32'd1 : 32'd0;
      25, 26, 27, 28, 29, 30, 31, 32: r = a + imm;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int sel_index(input logic [32:0] s);
    int r;
    r = -1;
    for (int k = 0; k < 33; k++) if (s[k] && r < 0) r = k;
    return r;
  endfunction

  // External ALU stand-in: registers its result one cycle after the strobe, 0 when no strobe
  always @(posedge CLK)
    ALU_RESULT <= (ALU_SEL == '0) ? 32'd0 : alu_ref(sel_index(ALU_SEL), ALU_RS1, ALU_RS2, ALU_IMM);

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input int op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input int tag);
    if (n == 0) begin
      REQ0_VALID = v; REQ0_OP = 6'(op); REQ0_RS1 = a; REQ0_RS2 = b; REQ0_IMM = imm; REQ0_TAG = 4'(tag);
    end else begin
      REQ1_VALID = v; REQ1_OP = 6'(op); REQ1_RS1 = a; REQ1_RS2 = b; REQ1_IMM = imm; REQ1_TAG = 4'(tag);
    end
  endtask

  task automatic do_reset;
    RST_N = 1'b0;
    RSP_READY = 1'b1;
    set_req(0, 1'b0, 0, 0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0, 0, 0);
    step;
    step;
    RST_N = 1'b1;
  endtask

  // Returns after the accepting edge; who = -1 if no accept within the budget
  task automatic wait_grant(output int who, output int waited);
    who = -1;
    waited = 0;
    while (who < 0 && waited < 40) begin
      #1;
      if (REQ0_READY && REQ0_VALID)      who = 0;
      else if (REQ1_READY && REQ1_VALID) who = 1;
      step;
      if (who < 0) waited++;
    end
  endtask

  // Called just after the accepting edge; returns once RSP_VALID is seen or the budget runs out
  task automatic wait_rsp(output int lat, output int sel_cyc, output logic [32:0] sel0);
    lat = 0;
    sel_cyc = 0;
    sel0 = ALU_SEL;
    while (!RSP_VALID && lat < 20) begin
      if (ALU_SEL != '0) sel_cyc++;
      step;
      lat++;
    end
  endtask

  task automatic run_one(input int src, input int op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input int tag, output int who, output int lat,
                         output int sel_cyc, output logic [32:0] sel0);
    int w;
    set_req(src, 1'b1, op, a, b, imm, tag);
    wait_grant(who, w);
    set_req(src, 1'b0, op, a, b, imm, tag);
    wait_rsp(lat, sel_cyc, sel0);
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({ALU_SEL, ALU_RS1, ALU_RS2, ALU_IMM} !== '0)
      $display("FAIL reset_alu_outputs got sel=%h rs1=%h rs2=%h imm=%h want all 0", ALU_SEL, ALU_RS1, ALU_RS2, ALU_IMM);
    else passed++;
    checks++;
    if ({RSP_VALID, RSP_SRC, RSP_TAG, RSP_DATA, RSP_ERR} !== '0)
      $display("FAIL reset_rsp_outputs got v=%b src=%b tag=%h data=%h err=%b want all 0", RSP_VALID, RSP_SRC, RSP_TAG, RSP_DATA, RSP_ERR);
    else passed++;
    #1;
    checks++;
    if ({REQ0_READY, REQ1_READY} !== 2'b00)
      $display("FAIL reset_ready got %b want 00", {REQ0_READY, REQ1_READY});
    else passed++;
  endtask

  task automatic test_add;
    int who, lat, selc;
    logic [32:0] sel0, exp_sel;
    do_reset;
    exp_sel = 33'd1 << 9;
    run_one(0, 9, 32'd5, 32'd7, 32'd0, 3, who, lat, selc, sel0);
    checks++; if (who !== 0) $display("FAIL add_grant got %0d want 0", who); else passed++;
    checks++; if (sel0 !== exp_sel) $display("FAIL add_sel got %h want %h", sel0, exp_sel); else passed++;
    checks++; if (selc !== 1) $display("FAIL add_sel_cycles got %0d want 1", selc); else passed++;
    checks++; if (lat !== 2) $display("FAIL add_latency got %0d want 2", lat); else passed++;
    checks++;
    if ({RSP_SRC, RSP_TAG, RSP_ERR, RSP_DATA} !== {1'b0, 4'd3, 1'b0, 32'd12})
      $display("FAIL add_rsp got src=%b tag=%0d err=%b data=%0d want src=0 tag=3 err=0 data=12", RSP_SRC, RSP_TAG, RSP_ERR, RSP_DATA);
    else passed++;
    step;
    checks++; if (RSP_VALID !== 1'b0) $display("FAIL add_handshake got valid=%b want 0", RSP_VALID); else passed++;
  endtask

  task automatic test_round_robin;
    int who, w, exp_who, model_last;
    do_reset;
    model_last = 1;
    set_req(0, 1'b1, 9, 32'd1, 32'd2, 32'd0, 1);
    set_req(1, 1'b1, 9, 32'd3, 32'd4, 32'd0, 2);
    for (int k = 0; k < 4; k++) begin
      wait_grant(who, w);
      exp_who = 1 - model_last;
      model_last = exp_who;
      checks++;
      if (who !== exp_who) $display("FAIL rr_grant[%0d] got %0d want %0d", k, who, exp_who); else passed++;
      if (k > 0) begin
        checks++;
        if (w + 1 !== 4) $display("FAIL rr_period[%0d] got %0d want 4", k, w + 1); else passed++;
      end
    end
    set_req(0, 1'b0, 0, 0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0, 0, 0);
    repeat (4) step;
  endtask

  task automatic test_branch;
    int who, lat, selc;
    logic [32:0] sel0;
    do_reset;
    run_one(1, 21, 32'hFFFF_FFFF, 32'd1, 32'd0, 5, who, lat, selc, sel0);
    checks++;
    if ({RSP_VALID, RSP_SRC, RSP_TAG, RSP_DATA} !== {1'b1, 1'b1, 4'd5, 32'd1})
      $display("FAIL blt_rsp got v=%b src=%b tag=%0d data=%h want v=1 src=1 tag=5 data=1", RSP_VALID, RSP_SRC, RSP_TAG, RSP_DATA);
    else passed++;
    step;
    run_one(1, 23, 32'hFFFF_FFFF, 32'd1, 32'd0, 6, who, lat, selc, sel0);
    checks++;
    if ({RSP_VALID, RSP_SRC, RSP_TAG, RSP_DATA} !== {1'b1, 1'b1, 4'd6, 32'd0})
      $display("FAIL bltu_rsp got v=%b src=%b tag=%0d data=%h want v=1 src=1 tag=6 data=0", RSP_VALID, RSP_SRC, RSP_TAG, RSP_DATA);
    else passed++;
    step;
  endtask

  task automatic test_stall;
    int who, lat, selc;
    logic [32:0] sel0, exp_sel;
    logic [37:0] snap;
    do_reset;
    RSP_READY = 1'b0;
    run_one(0, 10, 32'd20, 32'd8, 32'd0, 7, who, lat, selc, sel0);
    checks++;
    if ({RSP_VALID, RSP_DATA} !== {1'b1, 32'd12}) $display("FAIL stall_rsp got v=%b data=%0d want v=1 data=12", RSP_VALID, RSP_DATA);
    else passed++;
    snap = {RSP_SRC, RSP_TAG, RSP_DATA, RSP_ERR};
    set_req(0, 1'b1, 9, 32'd1, 32'd1, 32'd0, 1);
    set_req(1, 1'b1, 9, 32'd2, 32'd2, 32'd0, 2);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({RSP_VALID, RSP_SRC, RSP_TAG, RSP_DATA, RSP_ERR, REQ0_READY, REQ1_READY, ALU_SEL} !== {1'b1, snap, 2'b00, 33'd0})
        $display("FAIL stall_hold[%0d] got v=%b rsp=%h ready=%b%b sel=%h want v=1 rsp=%h ready=00 sel=0",
                 c, RSP_VALID, {RSP_SRC, RSP_TAG, RSP_DATA, RSP_ERR}, REQ0_READY, REQ1_READY, ALU_SEL, snap);
      else passed++;
      step;
    end
    RSP_READY = 1'b1;
    step;
    checks++; if (RSP_VALID !== 1'b0) $display("FAIL stall_release got valid=%b want 0", RSP_VALID); else passed++;
    #1;
    checks++;
    if ({REQ0_READY, REQ1_READY} !== 2'b01) $display("FAIL stall_next_grant got ready=%b%b want 01", REQ0_READY, REQ1_READY);
    else passed++;
    step;
    exp_sel = 33'd1 << 9;
    checks++;
    if ({ALU_SEL, ALU_RS1} !== {exp_sel, 32'd2}) $display("FAIL stall_next_issue got sel=%h rs1=%0d want sel=%h rs1=2", ALU_SEL, ALU_RS1, exp_sel);
    else passed++;
    set_req(0, 1'b0, 0, 0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0, 0, 0);
    repeat (4) step;
  endtask

  task automatic test_illegal;
    int who, lat, selc;
    logic [32:0] sel0, exp_sel;
    do_reset;
    run_one(0, 40, 32'd3, 32'd4, 32'd5, 9, who, lat, selc, sel0);
    checks++;
    if ({sel0, 32'(selc), 32'(lat)} !== {33'd0, 32'd0, 32'd2})
      $display("FAIL illegal40_timing got sel=%h sel_cycles=%0d lat=%0d want sel=0 sel_cycles=0 lat=2", sel0, selc, lat);
    else passed++;
    checks++;
    if ({RSP_ERR, RSP_TAG, RSP_DATA} !== {1'b1, 4'd9, 32'd0})
      $display("FAIL illegal40_rsp got err=%b tag=%0d data=%h want err=1 tag=9 data=0", RSP_ERR, RSP_TAG, RSP_DATA);
    else passed++;
    step;
    run_one(0, 33, 32'd3, 32'd4, 32'd5, 2, who, lat, selc, sel0);
    checks++;
    if ({sel0, RSP_ERR, RSP_DATA} !== {33'd0, 1'b1, 32'd0})
      $display("FAIL illegal33 got sel=%h err=%b data=%h want sel=0 err=1 data=0", sel0, RSP_ERR, RSP_DATA);
    else passed++;
    step;
    exp_sel = 33'd1 << 32;
    run_one(0, 32, 32'd100, 32'd0, 32'd12, 1, who, lat, selc, sel0);
    checks++;
    if ({sel0, RSP_ERR, RSP_DATA} !== {exp_sel, 1'b0, 32'd112})
      $display("FAIL legal32 got sel=%h err=%b data=%0d want sel=%h err=0 data=112", sel0, RSP_ERR, RSP_DATA, exp_sel);
    else passed++;
    step;
  endtask

  task automatic test_reset_mid;
    int who, w;
    logic seen;
    do_reset;
    set_req(0, 1'b1, 9, 32'd1, 32'd2, 32'd0, 4);
    wait_grant(who, w);
    set_req(0, 1'b0, 0, 0, 0, 0, 0);
    checks++; if (who !== 0) $display("FAIL midrst_grant got %0d want 0", who); else passed++;
    step;
    RST_N = 1'b0;
    step;
    RST_N = 1'b1;
    checks++;
    if ({RSP_VALID, ALU_SEL, RSP_DATA, RSP_TAG, ALU_RS1} !== '0)
      $display("FAIL midrst_outputs got v=%b sel=%h data=%h tag=%h rs1=%h want all 0", RSP_VALID, ALU_SEL, RSP_DATA, RSP_TAG, ALU_RS1);
    else passed++;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (RSP_VALID) seen = 1'b1;
      step;
    end
    checks++; if (seen !== 1'b0) $display("FAIL midrst_no_response got a response want none"); else passed++;
    set_req(0, 1'b1, 9, 32'd1, 32'd1, 32'd0, 1);
    set_req(1, 1'b1, 9, 32'd2, 32'd2, 32'd0, 2);
    #1;
    checks++;
    if ({REQ0_READY, REQ1_READY} !== 2'b10) $display("FAIL midrst_tie got ready=%b%b want 10", REQ0_READY, REQ1_READY);
    else passed++;
    set_req(0, 1'b0, 0, 0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random;
    int who, w, lat, selc, exp_who, model_last, stall;
    int cnt[2];
    bit pend[2];
    int p_op[2], p_tag[2];
    logic [31:0] p_a[2], p_b[2], p_imm[2];
    logic [32:0] sel0, exp_sel;
    logic [37:0] exp_rsp;
    do_reset;
    model_last = 1;
    cnt[0] = 0; cnt[1] = 0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int it = 0; it < 40; it++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && ($urandom_range(0, 1) == 1 || (n == 1 && !pend[0]))) begin
          pend[n] = 1'b1;
          p_op[n] = $urandom_range(0, 38);
          p_a[n] = $urandom; p_b[n] = $urandom; p_imm[n] = $urandom;
          p_tag[n] = $urandom_range(0, 15);
          set_req(n, 1'b1, p_op[n], p_a[n], p_b[n], p_imm[n], p_tag[n]);
        end
      end
      exp_who = (pend[0] && pend[1]) ? 1 - model_last : (pend[1] ? 1 : 0);
      model_last = exp_who;
      wait_grant(who, w);
      checks++;
      if (who !== exp_who) $display("FAIL rand_grant[%0d] got %0d want %0d", it, who, exp_who); else passed++;
      if (who < 0) break;
      pend[exp_who] = 1'b0;
      cnt[exp_who]++;
      set_req(exp_who, 1'b0, 0, 0, 0, 0, 0);
      RSP_READY = 1'b0;
      stall = $urandom_range(0, 3);
      wait_rsp(lat, selc, sel0);
      exp_sel = '0;
      if (p_op[exp_who] < 33) exp_sel[p_op[exp_who]] = 1'b1;
      exp_rsp = {1'(exp_who), 4'(p_tag[exp_who]), (p_op[exp_who] < 33) ?
                 alu_ref(p_op[exp_who], p_a[exp_who], p_b[exp_who], p_imm[exp_who]) : 32'd0,
                 1'(p_op[exp_who] >= 33)};
      checks++; if (lat !== 2) $display("FAIL rand_latency[%0d] got %0d want 2", it, lat); else passed++;
      checks++; if (sel0 !== exp_sel) $display("FAIL rand_sel[%0d] op=%0d got %h want %h", it, p_op[exp_who], sel0, exp_sel); else passed++;
      checks++;
      if ({RSP_SRC, RSP_TAG, RSP_DATA, RSP_ERR} !== exp_rsp)
        $display("FAIL rand_rsp[%0d] op=%0d got %h want %h", it, p_op[exp_who], {RSP_SRC, RSP_TAG, RSP_DATA, RSP_ERR}, exp_rsp);
      else passed++;
      for (int s = 0; s < stall; s++) begin
        step;
        checks++;
        if ({RSP_VALID, RSP_SRC, RSP_TAG, RSP_DATA, RSP_ERR} !== {1'b1, exp_rsp})
          $display("FAIL rand_hold[%0d] got v=%b rsp=%h want v=1 rsp=%h", it, RSP_VALID, {RSP_SRC, RSP_TAG, RSP_DATA, RSP_ERR}, exp_rsp);
        else passed++;
      end
      RSP_READY = 1'b1;
      step;
      checks++; if (RSP_VALID !== 1'b0) $display("FAIL rand_release[%0d] got valid=%b want 0", it, RSP_VALID); else passed++;
    end
`ifdef CORE_ALU_SCHED_STATS_EN
    checks++;
    if ({STAT0_CNT, STAT1_CNT} !== {16'(cnt[0]), 16'(cnt[1])})
      $display("FAIL rand_stats got %0d,%0d want %0d,%0d", STAT0_CNT, STAT1_CNT, cnt[0], cnt[1]);
    else passed++;
`endif
    set_req(0, 1'b0, 0, 0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset;
    test_add;
    test_round_robin;
    test_branch;
    test_stall;
    test_illegal;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/core_alu_sched.md
Name: core_alu_sched

Overview:
Two-requester scheduler that shares the single registered RV32I ALU (one-hot op strobes, 1-cycle registered RESULT) between the main execute path (requester 0) and an auxiliary client (requester 1, e.g. debug or address generation). It arbitrates round-robin, encodes an op code into the ALU one-hot select, and sequences the issue/wait/capture timing. The captured result is returned on a valid/ready response channel with source and tag.

Parameters:
TAG_W, 4, width of the opaque request tag passed through to the response
OP_W, 6, width of the request op code

Ports:
CLK  in  1  clock
RST_N  in  1  reset, synchronous, active-low
REQn_VALID  in  1  request valid, n=0,1
REQn_READY  out  1  request accepted this cycle, n=0,1
REQn_OP  in  OP_W  op code 0..32 (see Behaviour), n=0,1
REQn_RS1 / REQn_RS2 / REQn_IMM  in  32 each  operands, n=0,1
REQn_TAG  in  TAG_W  tag, n=0,1
ALU_SEL  out  33  one-hot op strobes to ALU, bit k = op code k
ALU_RS1 / ALU_RS2 / ALU_IMM  out  32 each  registered ALU operands
ALU_RESULT  in  32  ALU registered RESULT
RSP_VALID  out  1  response valid
RSP_READY  in  1  response consumer ready
RSP_SRC  out  1  granted requester index
RSP_TAG  out  TAG_W  tag of the completed request
RSP_DATA  out  32  ALU result
RSP_ERR  out  1  illegal op code (>=33)

Behaviour:
- Op codes: 0-8 ADDI,SLTI,SLTIU,XORI,ORI,ANDI,SLLI,SRLI,SRAI; 9-18 ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND; 19-24 BEQ,BNE,BLT,BGE,BLTU,BGEU; 25-32 LB,LH,LW,LBU,LHU,SB,SH,SW.
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset sets IDLE; all outputs 0; last-grant register LAST=1, so requester 0 wins the first tie.
- IDLE: REQn_READY is combinational. If exactly one requester is valid, that requester is granted. If both are valid, the requester != LAST is granted. READY is asserted only for the granted requester and only in IDLE.
- On accept (edge E0): register operands to ALU_*, ALU_SEL = one-hot(op), latch SRC, TAG and ERR, update LAST, go to ISSUE.
- Illegal op code: ALU_SEL = 0, ERR latched as 1, and the sequence still runs. RSP_DATA is whatever the ALU returns (0).
- ISSUE (1 cycle): ALU inputs are stable, and the ALU registers RESULT at edge E1. At E1, ALU_SEL clears to 0 and the state goes to WAIT.
- WAIT (1 cycle): at E2, capture ALU_RESULT into RSP_DATA, set RSP_VALID=1, go to RESP.
- RESP: RSP_* is held stable while RSP_VALID && !RSP_READY. On handshake, RSP_VALID goes to 0 and the state returns to IDLE.
- Timing: accept-to-RSP_VALID latency is 2 cycles. Minimum accept period is 4 cycles with RSP_READY tied high.
- ALU_RS1/RS2/IMM keep their last values after issue; only ALU_SEL gates ALU activity.
- Requests presented outside IDLE see READY=0. The requester must hold VALID and payload until accepted.
- Synchronous reset mid-operation drops the in-flight op: state goes to IDLE, RSP_VALID=0, ALU_SEL=0, LAST=1. No response is produced for that op.

Optional Feature:
CORE_ALU_SCHED_STATS_EN
- Defined: adds input STAT_CLR (1b) and outputs STAT0_CNT and STAT1_CNT (16b each). Each counter counts accepts for its requester and saturates at 0xFFFF. Reset or STAT_CLR zeroes the counters; if STAT_CLR coincides with an accept, STAT_CLR wins.
- Undefined: none of these ports or counters exist, and scheduling behaviour is identical.

Test Plan:
- REQ0 op=9 (ADD), RS1=5, RS2=7, tag=3, RSP_READY=1 -> ALU_SEL bit9 high for exactly 1 cycle; RSP_VALID 2 cycles after accept with DATA=12, SRC=0, TAG=3, ERR=0.
- Both valid continuously after reset, RSP_READY=1 -> grants alternate 0,1,0,1, with accepts every 4 cycles.
- REQ1 op=21 (BLT), RS1=0xFFFFFFFF, RS2=1 -> DATA=1, SRC=1. Repeat with op=23 (BLTU) -> DATA=0.
- RSP_READY=0 for 5 cycles after RSP_VALID -> RSP_* held stable, both READY=0, and no new ALU_SEL activity. After RSP_READY rises, the next accept occurs the cycle after the return to IDLE.
- REQ0 op=40 -> ALU_SEL stays 0, RSP_ERR=1, RSP_DATA=0.
- RST_N low for 1 cycle while in WAIT -> no response; outputs are 0 on the next cycle, and the next tie grants requester 0.
